// File: rtl/hmc_rf_pkg.sv
// ----------------------------------------------------------------------------
// hmc_rf_pkg
// Shared definitions for the HMC RF access-bus responder:
//   - register map addresses of the implemented registers
//   - responder FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package hmc_rf_pkg;

    // Register map. Every address above RF_ADDR_ERROR_CNT is unmapped.
    localparam int unsigned RF_ADDR_CONTROL   = 0;
    localparam int unsigned RF_ADDR_STATUS    = 1;
    localparam int unsigned RF_ADDR_SCRATCH   = 2;
    localparam int unsigned RF_ADDR_EVENT_CNT = 3;
    localparam int unsigned RF_ADDR_ERROR_CNT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } rf_resp_state_t;

endpackage : hmc_rf_pkg

// File: rtl/hmc_rf_sat_counter.sv
// ----------------------------------------------------------------------------
// hmc_rf_sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : clock
//   res_n  : asynchronous active-low reset, clears the count
//   inc    : count one in this cycle (ignored once at all-ones)
//   clr    : clear the count; clr together with inc leaves the count at 1
//   cnt    : current count
// ----------------------------------------------------------------------------
module hmc_rf_sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            // The clear wins over the old value but the event of this
            // same cycle is still counted.
            cnt_d = WIDTH'(inc);
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : hmc_rf_sat_counter

// File: rtl/hmc_rf_responder.sv
// ----------------------------------------------------------------------------
// hmc_rf_responder
// Register-file target on the HMC RF access bus. Serves read/write requests
// to a small register map (CONTROL, STATUS, SCRATCH, EVENT_COUNT,
// ERROR_COUNT) with a fixed completion latency of ACCESS_LATENCY cycles.
//
// Ports:
//   clk, res_n          : clock, asynchronous active-low reset
//   rf_address          : register address of the request
//   rf_write_data       : write data of the request
//   rf_read_enable      : read request (level)
//   rf_write_enable     : write request (level)
//   rf_read_data        : registered read data, held until the next completion
//   rf_access_complete  : one-cycle completion pulse
//   rf_invalid_address  : invalid-access flag, only meaningful with complete
//   status_in           : live status, returned by reads of STATUS
//   event_in            : event strobe, counted once per high cycle
//   ctrl_out            : CONTROL register contents
//
// Handshake: a request is the level of rf_read_enable/rf_write_enable; the
// initiator keeps address, data and enable stable until it sees
// rf_access_complete, then drops the enable. The responder captures the
// request when it leaves IDLE, pulses rf_access_complete for one cycle
// ACCESS_LATENCY cycles later, and will not accept a new request until both
// enables have been seen low, so a held enable never starts a second access.
// Both enables high at once is answered as an invalid access.
//
// FSM state is visible on the internal signal state_q for bound checkers.
// ----------------------------------------------------------------------------
module hmc_rf_responder
    import hmc_rf_pkg::*;
#(
    parameter int HMC_RF_WWIDTH  = 64,
    parameter int HMC_RF_RWIDTH  = 64,
    parameter int HMC_RF_AWIDTH  = 4,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [HMC_RF_AWIDTH-1:0] rf_address,
    input  logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    input  logic                     rf_read_enable,
    input  logic                     rf_write_enable,
    output logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    output logic                     rf_access_complete,
    output logic                     rf_invalid_address,
    input  logic [HMC_RF_RWIDTH-1:0] status_in,
    input  logic                     event_in,
    output logic [HMC_RF_RWIDTH-1:0] ctrl_out
);

    localparam int AW    = HMC_RF_AWIDTH;
    localparam int RW    = HMC_RF_RWIDTH;
    // The counter only ever holds values 0 .. ACCESS_LATENCY-1.
    localparam int LAT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (HMC_RF_WWIDTH != HMC_RF_RWIDTH) begin : g_width_check
        $error("hmc_rf_responder: HMC_RF_WWIDTH must equal HMC_RF_RWIDTH");
    end
    if (ACCESS_LATENCY < 1) begin : g_latency_check
        $error("hmc_rf_responder: ACCESS_LATENCY must be at least 1");
    end
    if (HMC_RF_AWIDTH < 3) begin : g_addr_check
        $error("hmc_rf_responder: HMC_RF_AWIDTH too small for the register map");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rf_resp_state_t    state_q,      state_d;
    logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;
    logic [AW-1:0]     addr_q,       addr_d;
    logic [RW-1:0]     wdata_q,      wdata_d;
    logic              is_write_q,   is_write_d;
    logic              invalid_q,    invalid_d;
    logic [RW-1:0]     ctrl_q,       ctrl_d;
    logic [RW-1:0]     scratch_q,    scratch_d;
    logic [RW-1:0]     rdata_q,      rdata_d;

    logic [RW-1:0]     event_cnt;
    logic [RW-1:0]     error_cnt;
    logic              in_done;
    logic              valid_write;
    logic              event_clr;
    logic              error_clr;
    logic              error_inc;
    logic [RW-1:0]     read_mux;

    // ------------------------------------------------------------------
    // Read data selection, evaluated on the captured address. Counters
    // return the value held during DONE, before any clear takes effect.
    // ------------------------------------------------------------------
    always_comb begin
        read_mux = '0;
        case (addr_q)
            AW'(RF_ADDR_CONTROL):   read_mux = ctrl_q;
            AW'(RF_ADDR_STATUS):    read_mux = status_in;
            AW'(RF_ADDR_SCRATCH):   read_mux = scratch_q;
            AW'(RF_ADDR_EVENT_CNT): read_mux = event_cnt;
            AW'(RF_ADDR_ERROR_CNT): read_mux = error_cnt;
            default:                read_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        invalid_d  = invalid_q;
        ctrl_d     = ctrl_q;
        scratch_d  = scratch_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (rf_read_enable || rf_write_enable) begin
                    addr_d     = rf_address;
                    wdata_d    = rf_write_data;
                    is_write_d = rf_write_enable;
                    invalid_d  = (rf_read_enable && rf_write_enable) ||
                                 (rf_address > AW'(RF_ADDR_ERROR_CNT));
                    lat_cnt_d  = LAT_W'(ACCESS_LATENCY - 1);
                    // With a latency of one the access completes in the very
                    // next cycle, so the wait phase is skipped entirely.
                    state_d    = (ACCESS_LATENCY == 1) ? DONE : WAIT;
                end
            end

            WAIT: begin
                // Leave when this decrement reaches zero; that places DONE
                // exactly ACCESS_LATENCY cycles after the request was sampled.
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = RELEASE;
                rdata_d = '0;
                if (!invalid_q) begin
                    if (is_write_q) begin
                        case (addr_q)
                            AW'(RF_ADDR_CONTROL): ctrl_d    = wdata_q;
                            AW'(RF_ADDR_SCRATCH): scratch_d = wdata_q;
                            default: ;
                        endcase
                    end else begin
                        rdata_d = read_mux;
                    end
                end
            end

            RELEASE: begin
                if (!rf_read_enable && !rf_write_enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            invalid_q  <= 1'b0;
            ctrl_q     <= '0;
            scratch_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            invalid_q  <= invalid_d;
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Counter control. A clear of ERROR_COUNT is a valid access, so its
    // clear and its increment can never happen in the same cycle.
    // ------------------------------------------------------------------
    assign in_done     = (state_q == DONE);
    assign valid_write = in_done && !invalid_q && is_write_q;
    assign event_clr   = valid_write && (addr_q == AW'(RF_ADDR_EVENT_CNT));
    assign error_clr   = valid_write && (addr_q == AW'(RF_ADDR_ERROR_CNT));
    assign error_inc   = in_done && invalid_q;

    hmc_rf_sat_counter #(
        .WIDTH (RW)
    ) u_event_cnt (
        .clk   (clk),
        .res_n (res_n),
        .inc   (event_in),
        .clr   (event_clr),
        .cnt   (event_cnt)
    );

    hmc_rf_sat_counter #(
        .WIDTH (RW)
    ) u_error_cnt (
        .clk   (clk),
        .res_n (res_n),
        .inc   (error_inc),
        .clr   (error_clr),
        .cnt   (error_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rf_read_data       = rdata_q;
    assign rf_access_complete = in_done;
    assign rf_invalid_address = in_done && invalid_q;
    assign ctrl_out           = ctrl_q;

endmodule : hmc_rf_responder
